// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the 8 x 32 register FIFO controller.
package fifo_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] FULL_COUNT  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] EMPTY_COUNT = '0;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } state_e;

endpackage

// File: rtl/fifo_ns.sv
// Resolves the requested operation for this cycle into the next state and the
// next head/tail/count values; purely combinational.
module fifo_ns
  import fifo_pkg::*;
(
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] head,
  input  logic [ADDR_WIDTH-1:0] tail,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic [2:0]            state_d,
  output logic [ADDR_WIDTH-1:0] head_d,
  output logic [ADDR_WIDTH-1:0] tail_d,
  output logic [CNT_WIDTH-1:0]  count_d,
  output logic                  wr_commit
);

  logic is_full;
  logic is_empty;

  assign is_full  = (count == FULL_COUNT);
  assign is_empty = (count == EMPTY_COUNT);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = NO_OP;
    head_d    = head;
    tail_d    = tail;
    count_d   = count;
    wr_commit = 1'b0;

    case ({wr_en, rd_en})
      2'b10: begin
        if (is_full) begin
          state_d = WR_ERROR;
        end else begin
          state_d   = WRITE;
          tail_d    = tail + 1'b1;  // 3-bit overflow gives the 7 -> 0 wrap
          count_d   = count + 1'b1;
          wr_commit = 1'b1;
        end
      end
      2'b01: begin
        if (is_empty) begin
          state_d = RD_ERROR;
        end else begin
          state_d = READ;
          head_d  = head + 1'b1;
          count_d = count - 1'b1;
        end
      end
      // Simultaneous requests are refused outright; the requester retries.
      default: state_d = NO_OP;
    endcase
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Write side and control of the 8 x 32 register FIFO: storage, pointers,
// occupancy and operation state; the head pointer selects the external read mux.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] reg_out0,
  output logic [DATA_WIDTH-1:0] reg_out1,
  output logic [DATA_WIDTH-1:0] reg_out2,
  output logic [DATA_WIDTH-1:0] reg_out3,
  output logic [DATA_WIDTH-1:0] reg_out4,
  output logic [DATA_WIDTH-1:0] reg_out5,
  output logic [DATA_WIDTH-1:0] reg_out6,
  output logic [DATA_WIDTH-1:0] reg_out7,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  state_e                state_q;
  logic [2:0]            state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  fifo_ns u_ns (
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .head      (head_q),
    .tail      (tail_q),
    .count     (count_q),
    .state_d   (state_d),
    .head_d    (head_d),
    .tail_d    (tail_d),
    .count_d   (count_d),
    .wr_commit (wr_commit)
  );

  // NOTE: non-blocking assignments throughout so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: storage is reset because the mux outputs are visible ports and must never be X.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_e'(state_d);
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (wr_commit) begin
        mem_q[tail_q] <= din;
      end
    end
  end

  assign reg_out0 = mem_q[0];
  assign reg_out1 = mem_q[1];
  assign reg_out2 = mem_q[2];
  assign reg_out3 = mem_q[3];
  assign reg_out4 = mem_q[4];
  assign reg_out5 = mem_q[5];
  assign reg_out6 = mem_q[6];
  assign reg_out7 = mem_q[7];

  // Flags come from the count: head == tail alone cannot tell empty from full.
  assign rd_addr    = head_q;
  assign data_count = count_q;
  assign full       = (count_q == FULL_COUNT);
  assign empty      = (count_q == EMPTY_COUNT);

  assign wr_ack = (state_q == WRITE);
  assign wr_err = (state_q == WR_ERROR);
  assign rd_ack = (state_q == READ);
  assign rd_err = (state_q == RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboarded bench for fifo_ctrl: stimulus queues expected status pulses,
// a negedge monitor pops and compares them, including the data read via the mux.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] reg_out0, reg_out1, reg_out2, reg_out3;
  logic [31:0] reg_out4, reg_out5, reg_out6, reg_out7;
  logic [2:0]  rd_addr;
  logic        full, empty;
  logic [3:0]  data_count;
  logic        wr_ack, wr_err, rd_ack, rd_err;

  fifo_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .reg_out0   (reg_out0),
    .reg_out1   (reg_out1),
    .reg_out2   (reg_out2),
    .reg_out3   (reg_out3),
    .reg_out4   (reg_out4),
    .reg_out5   (reg_out5),
    .reg_out6   (reg_out6),
    .reg_out7   (reg_out7),
    .rd_addr    (rd_addr),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [8];
  assign regs[0] = reg_out0;
  assign regs[1] = reg_out1;
  assign regs[2] = reg_out2;
  assign regs[3] = reg_out3;
  assign regs[4] = reg_out4;
  assign regs[5] = reg_out5;
  assign regs[6] = reg_out6;
  assign regs[7] = reg_out7;

  typedef enum logic [1:0] {EV_WACK, EV_WERR, EV_RACK, EV_RERR} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_ev(input ev_e kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Inputs are applied just after a rising edge and sampled at the next one.
  task automatic op(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
  endtask

  // Monitor: pulses appear at the negedge after the request edge; read data is
  // taken from the mux in the cycle rd_en is presented, as a consumer would.
  logic [31:0] rd_data_cap;
  int          npulse;
  ev_e         got_kind;
  exp_t        cur;

  initial begin
    rd_data_cap = '0;
    forever begin
      @(negedge clk);
      npulse = int'(wr_ack) + int'(wr_err) + int'(rd_ack) + int'(rd_err);
      if (npulse > 1) begin
        total++;
        bad++;
        $display("FAIL multi_pulse: got %b, expected one-hot", {wr_ack, wr_err, rd_ack, rd_err});
      end else if (npulse == 1) begin
        got_kind = wr_ack ? EV_WACK : wr_err ? EV_WERR : rd_ack ? EV_RACK : EV_RERR;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got kind %0d, expected none", got_kind);
        end else begin
          cur = exp_q.pop_front();
          check("pulse_kind", 32'(got_kind), 32'(cur.kind));
          if (cur.kind == EV_RACK) check("rd_data", rd_data_cap, cur.data);
        end
      end
      if (reset_n && rd_en && !wr_en && !empty) rd_data_cap = regs[rd_addr];
    end
  end

  logic [31:0] drain_vals [7];

  initial begin
    // 1. Reset held for two clocks
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(data_count), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_pulses", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
    for (int i = 0; i < 8; i++) check("rst_reg", regs[i], 32'd0);
    reset_n = 1'b1;

    // 2. Fill to full, then one overflow write
    for (int i = 0; i < 8; i++) begin
      expect_ev(EV_WACK, '0);
      op(1'b1, 1'b0, 32'h1111_1111 * 32'(i + 1));
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(data_count), 32'd8);
    expect_ev(EV_WERR, '0);
    op(1'b1, 1'b0, 32'hDEAD_BEEF);
    check("ovf_reg0", regs[0], 32'h1111_1111);
    check("ovf_count", 32'(data_count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);

    // 3. Read three, write two across the wrap, then drain all seven
    for (int i = 0; i < 3; i++) begin
      expect_ev(EV_RACK, 32'h1111_1111 * 32'(i + 1));
      op(1'b0, 1'b1, '0);
    end
    expect_ev(EV_WACK, '0);
    op(1'b1, 1'b0, 32'hAAAA_AAAA);
    expect_ev(EV_WACK, '0);
    op(1'b1, 1'b0, 32'hBBBB_BBBB);
    check("wrap_reg0", regs[0], 32'hAAAA_AAAA);
    check("wrap_reg1", regs[1], 32'hBBBB_BBBB);
    check("wrap_count", 32'(data_count), 32'd7);
    check("wrap_rd_addr", 32'(rd_addr), 32'd3);

    drain_vals = '{32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777,
                   32'h8888_8888, 32'hAAAA_AAAA, 32'hBBBB_BBBB};
    for (int i = 0; i < 7; i++) begin
      expect_ev(EV_RACK, drain_vals[i]);
      op(1'b0, 1'b1, '0);
    end
    check("drain_count", 32'(data_count), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rd_addr", 32'(rd_addr), 32'd2);

    // 4. Underflow
    expect_ev(EV_RERR, '0);
    op(1'b0, 1'b1, '0);
    check("udf_rd_addr", 32'(rd_addr), 32'd2);
    check("udf_count", 32'(data_count), 32'd0);
    check("udf_empty", 32'(empty), 32'd1);

    // 5. Simultaneous request at count 4 (writes land in reg2..reg5)
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_WACK, '0);
      op(1'b1, 1'b0, 32'hC000_0000 + 32'(i));
    end
    check("pre_sim_count", 32'(data_count), 32'd4);
    op(1'b1, 1'b1, 32'hFFFF_FFFF);
    check("sim_count", 32'(data_count), 32'd4);
    check("sim_rd_addr", 32'(rd_addr), 32'd2);
    check("sim_reg2", regs[2], 32'hC000_0000);
    check("sim_reg6", regs[6], 32'h7777_7777);
    check("sim_state", 32'(dut.state_q), 32'(NO_OP));

    // 6. Reset asserted during a write at count 5
    expect_ev(EV_WACK, '0);
    op(1'b1, 1'b0, 32'hC000_0004);
    check("pre_rst_count", 32'(data_count), 32'd5);
    reset_n = 1'b0;
    op(1'b1, 1'b0, 32'h5555_5555);
    check("mrst_count", 32'(data_count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_full", 32'(full), 32'd0);
    check("mrst_rd_addr", 32'(rd_addr), 32'd0);
    check("mrst_reg7", regs[7], 32'd0);
    reset_n = 1'b1;

    // Recovery after reset
    expect_ev(EV_WACK, '0);
    op(1'b1, 1'b0, 32'hCAFE_F00D);
    check("rec_reg0", regs[0], 32'hCAFE_F00D);
    expect_ev(EV_RACK, 32'hCAFE_F00D);
    op(1'b0, 1'b1, '0);
    op(1'b0, 1'b0, '0);
    check("rec_count", 32'(data_count), 32'd0);

    // Bounded wait for the monitor to consume every queued expectation
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
